// File: rtl/decode_exe_reg.sv
`default_nettype none
// ============================================================================
// Module   : decode_exe_reg
// Purpose  : Decode-to-execute pipeline register with load-use interlock,
//            branch flush and downstream hold. Optional HAZARD_STATS_EN macro
//            adds saturating bubble/flush counters.
// Revision : 1.0  initial release
// ============================================================================
module decode_exe_reg #(
    parameter int DATA_W   = 32,
    parameter int ALU_OP_W = 4,
    parameter int LOAD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dec_valid,
    input  logic [3:0]          dec_ra,
    input  logic [3:0]          dec_rb,
    input  logic [3:0]          dec_rd,
    input  logic                dec_re_a,
    input  logic                dec_re_b,
    input  logic                dec_we,
    input  logic                dec_mem_re,
    input  logic                dec_mem_we,
    input  logic [ALU_OP_W-1:0] dec_alu_op,
    input  logic [DATA_W-1:0]   dec_opa,
    input  logic [DATA_W-1:0]   dec_opb,
    input  logic                flush,
    input  logic                ext_hold,
    output logic                exe_valid,
    output logic [3:0]          exe_ra,
    output logic [3:0]          exe_rb,
    output logic [3:0]          exe_rd,
    output logic                exe_re_a,
    output logic                exe_re_b,
    output logic                exe_we,
    output logic                exe_mem_re,
    output logic                exe_mem_we,
    output logic [ALU_OP_W-1:0] exe_alu_op,
    output logic [DATA_W-1:0]   exe_opa,
    output logic [DATA_W-1:0]   exe_opb,
    output logic                stall_fd
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]         stat_bubbles,
    output logic [15:0]         stat_flushes
`endif
);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic [1:0] c_CNT_INIT = 2'(LOAD_LAT - 1);

    typedef struct packed {
        logic                valid;
        logic [3:0]          ra;
        logic [3:0]          rb;
        logic [3:0]          rd;
        logic                re_a;
        logic                re_b;
        logic                we;
        logic                mem_re;
        logic                mem_we;
        logic [ALU_OP_W-1:0] alu_op;
        logic [DATA_W-1:0]   opa;
        logic [DATA_W-1:0]   opb;
    } exe_t;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    exe_t       r_exe;
    exe_t       w_dec;
    logic       w_haz;
    logic       w_hold;
    logic       w_stall_bubble;
    logic       w_bubble;

    assign w_dec = {dec_valid, dec_ra, dec_rb, dec_rd, dec_re_a, dec_re_b,
                    dec_we, dec_mem_re, dec_mem_we, dec_alu_op, dec_opa, dec_opb};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = 2'd0;
        end else if (ext_hold) begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
        end else if (r_state == S_RUN) begin
            if (w_haz && (LOAD_LAT > 1)) begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = c_CNT_INIT;
            end
        end else begin
            w_cnt_nxt = r_cnt - 2'd1;
            if (r_cnt == 2'd1) begin
                w_state_nxt = S_RUN;
            end
        end
    end

    // Output / control decode
    always_comb begin
        w_haz = (r_state == S_RUN) && r_exe.valid && r_exe.mem_re && r_exe.we
                && dec_valid
                && ((dec_re_a && (dec_ra == r_exe.rd)) || (dec_re_b && (dec_rb == r_exe.rd)));
        stall_fd       = (w_haz || (r_state == S_WAIT) || ext_hold) && !flush;
        w_hold         = ext_hold && !flush;
        w_stall_bubble = !flush && !ext_hold && (w_haz || (r_state == S_WAIT));
        w_bubble       = flush || w_stall_bubble || !dec_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exe <= '0;
        end else if (!w_hold) begin
            r_exe <= w_bubble ? exe_t'('0) : w_dec;
        end
    end

    assign exe_valid  = r_exe.valid;
    assign exe_ra     = r_exe.ra;
    assign exe_rb     = r_exe.rb;
    assign exe_rd     = r_exe.rd;
    assign exe_re_a   = r_exe.re_a;
    assign exe_re_b   = r_exe.re_b;
    assign exe_we     = r_exe.we;
    assign exe_mem_re = r_exe.mem_re;
    assign exe_mem_we = r_exe.mem_we;
    assign exe_alu_op = r_exe.alu_op;
    assign exe_opa    = r_exe.opa;
    assign exe_opb    = r_exe.opb;

`ifdef HAZARD_STATS_EN
    logic [15:0] r_stat_bubbles;
    logic [15:0] r_stat_flushes;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_bubbles <= 16'd0;
            r_stat_flushes <= 16'd0;
        end else begin
            if (w_stall_bubble && (r_stat_bubbles != 16'hFFFF)) begin
                r_stat_bubbles <= r_stat_bubbles + 16'd1;
            end
            if (flush && (r_stat_flushes != 16'hFFFF)) begin
                r_stat_flushes <= r_stat_flushes + 16'd1;
            end
        end
    end

    assign stat_bubbles = r_stat_bubbles;
    assign stat_flushes = r_stat_flushes;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_exe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_exe_reg
// Purpose  : Directed bench for decode_exe_reg; two instances (LOAD_LAT 1 and 3)
//            share one stimulus stream. Counter checks use HAZARD_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_decode_exe_reg;

    localparam int IW = 86;

    logic clk = 1'b0;
    logic rst_n;
    logic dec_valid, dec_re_a, dec_re_b, dec_we, dec_mem_re, dec_mem_we;
    logic [3:0] dec_ra, dec_rb, dec_rd, dec_alu_op;
    logic [31:0] dec_opa, dec_opb;
    logic flush, ext_hold;

    logic d1_valid, d1_re_a, d1_re_b, d1_we, d1_mem_re, d1_mem_we, d1_stall;
    logic [3:0] d1_ra, d1_rb, d1_rd, d1_alu_op;
    logic [31:0] d1_opa, d1_opb;
    logic d3_valid, d3_re_a, d3_re_b, d3_we, d3_mem_re, d3_mem_we, d3_stall;
    logic [3:0] d3_ra, d3_rb, d3_rd, d3_alu_op;
    logic [31:0] d3_opa, d3_opb;
`ifdef HAZARD_STATS_EN
    logic [15:0] d1_sb, d1_sf, d3_sb, d3_sf;
`endif

    logic [IW-1:0] d1_exe, d3_exe;
    assign d1_exe = {d1_valid, d1_ra, d1_rb, d1_rd, d1_re_a, d1_re_b, d1_we,
                     d1_mem_re, d1_mem_we, d1_alu_op, d1_opa, d1_opb};
    assign d3_exe = {d3_valid, d3_ra, d3_rb, d3_rd, d3_re_a, d3_re_b, d3_we,
                     d3_mem_re, d3_mem_we, d3_alu_op, d3_opa, d3_opb};

    always #5 clk = ~clk;

    decode_exe_reg #(.DATA_W(32), .ALU_OP_W(4), .LOAD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ra(dec_ra), .dec_rb(dec_rb),
        .dec_rd(dec_rd), .dec_re_a(dec_re_a), .dec_re_b(dec_re_b), .dec_we(dec_we),
        .dec_mem_re(dec_mem_re), .dec_mem_we(dec_mem_we), .dec_alu_op(dec_alu_op),
        .dec_opa(dec_opa), .dec_opb(dec_opb), .flush(flush), .ext_hold(ext_hold),
        .exe_valid(d1_valid), .exe_ra(d1_ra), .exe_rb(d1_rb), .exe_rd(d1_rd),
        .exe_re_a(d1_re_a), .exe_re_b(d1_re_b), .exe_we(d1_we), .exe_mem_re(d1_mem_re),
        .exe_mem_we(d1_mem_we), .exe_alu_op(d1_alu_op), .exe_opa(d1_opa), .exe_opb(d1_opb),
        .stall_fd(d1_stall)
`ifdef HAZARD_STATS_EN
        , .stat_bubbles(d1_sb), .stat_flushes(d1_sf)
`endif
    );

    decode_exe_reg #(.DATA_W(32), .ALU_OP_W(4), .LOAD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ra(dec_ra), .dec_rb(dec_rb),
        .dec_rd(dec_rd), .dec_re_a(dec_re_a), .dec_re_b(dec_re_b), .dec_we(dec_we),
        .dec_mem_re(dec_mem_re), .dec_mem_we(dec_mem_we), .dec_alu_op(dec_alu_op),
        .dec_opa(dec_opa), .dec_opb(dec_opb), .flush(flush), .ext_hold(ext_hold),
        .exe_valid(d3_valid), .exe_ra(d3_ra), .exe_rb(d3_rb), .exe_rd(d3_rd),
        .exe_re_a(d3_re_a), .exe_re_b(d3_re_b), .exe_we(d3_we), .exe_mem_re(d3_mem_re),
        .exe_mem_we(d3_mem_we), .exe_alu_op(d3_alu_op), .exe_opa(d3_opa), .exe_opb(d3_opb),
        .stall_fd(d3_stall)
`ifdef HAZARD_STATS_EN
        , .stat_bubbles(d3_sb), .stat_flushes(d3_sf)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(
        input logic v, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd,
        input logic re_a, input logic re_b, input logic we, input logic mr, input logic mw,
        input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        return {v, ra, rb, rd, re_a, re_b, we, mr, mw, op, a, b};
    endfunction

    task automatic drive(input logic [IW-1:0] ins);
        {dec_valid, dec_ra, dec_rb, dec_rd, dec_re_a, dec_re_b, dec_we,
         dec_mem_re, dec_mem_we, dec_alu_op, dec_opa, dec_opb} = ins;
    endtask

    // Advance one rising edge and step just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [IW-1:0] c_bub, i_a, i_l, i_c1, i_l2, i_s, i_l3, i_c3, i_n, i_m, i_l4, i_c4;

    initial begin
        c_bub = '0;
        i_a   = mk(1, 4'd2, 4'd3, 4'd1, 1, 1, 1, 0, 0, 4'h3, 32'h10, 32'h20);
        i_l   = mk(1, 4'd1, 4'd0, 4'd5, 1, 0, 1, 1, 0, 4'h0, 32'h100, 32'h4);
        i_c1  = mk(1, 4'd5, 4'd7, 4'd6, 1, 0, 1, 0, 0, 4'h1, 32'hAAAA, 32'h5555);
        i_l2  = mk(1, 4'd2, 4'd0, 4'd0, 1, 0, 1, 1, 0, 4'h0, 32'h200, 32'h8);
        i_s   = mk(1, 4'd3, 4'd0, 4'd0, 1, 1, 0, 0, 1, 4'h2, 32'h300, 32'hDEAD);
        i_l3  = mk(1, 4'd1, 4'd2, 4'd4, 1, 0, 1, 1, 0, 4'h0, 32'h400, 32'hC);
        i_c3  = mk(1, 4'd4, 4'd1, 4'd7, 1, 0, 1, 0, 0, 4'h5, 32'h11, 32'h22);
        i_n   = mk(1, 4'd6, 4'd7, 4'd8, 1, 1, 1, 0, 0, 4'h6, 32'hCAFE, 32'hBEEF);
        i_m   = mk(1, 4'd9, 4'd10, 4'd11, 1, 1, 1, 0, 0, 4'h7, 32'h1234, 32'h5678);
        i_l4  = mk(1, 4'd1, 4'd1, 4'd8, 1, 0, 1, 1, 0, 4'h0, 32'h500, 32'h10);
        i_c4  = mk(1, 4'd2, 4'd8, 4'd3, 0, 1, 1, 0, 0, 4'h4, 32'h77, 32'h88);

        rst_n = 1'b0; flush = 1'b0; ext_hold = 1'b0;
        drive(c_bub);
        tick(); tick();
        chk("rst_exe1", d1_exe, c_bub);
        chk("rst_exe3", d3_exe, c_bub);
        chk("rst_stall1", d1_stall, 1'b0);
        rst_n = 1'b1;

        // Pass-through
        drive(i_a); #1;
        chk("pt_stall1", d1_stall, 1'b0);
        chk("pt_stall3", d3_stall, 1'b0);
        tick();
        chk("pt_exe1", d1_exe, i_a);
        chk("pt_exe3", d3_exe, i_a);

        // Load-use through ra
        drive(i_l); #1;
        chk("lu_noload_stall", d1_stall, 1'b0);
        tick();
        chk("lu_load1", d1_exe, i_l);
        drive(i_c1); #1;
        chk("lu_haz_stall1", d1_stall, 1'b1);
        chk("lu_haz_stall3", d3_stall, 1'b1);
        tick();
        chk("lu_e1_exe1", d1_exe, c_bub);
        chk("lu_e1_exe3", d3_exe, c_bub);
        chk("lu_e1_stall1", d1_stall, 1'b0);
        chk("lu_e1_stall3", d3_stall, 1'b1);
        tick();
        chk("lu_e2_exe1", d1_exe, i_c1);
        chk("lu_e2_exe3", d3_exe, c_bub);
        chk("lu_e2_stall3", d3_stall, 1'b1);
        tick();
        chk("lu_e3_exe3", d3_exe, c_bub);
        chk("lu_e3_stall3", d3_stall, 1'b0);
        tick();
        chk("lu_e4_exe3", d3_exe, i_c1);
`ifdef HAZARD_STATS_EN
        chk("stat_lu_sum", 16'(d1_sb + d3_sb), 16'd4);
`endif

        // Store after load through rb, destination R0
        drive(i_l2);
        tick();
        chk("st_load3", d3_exe, i_l2);
        drive(i_s); #1;
        chk("st_haz_stall1", d1_stall, 1'b1);
        chk("st_haz_stall3", d3_stall, 1'b1);
        tick();
        chk("st_e1_exe1", d1_exe, c_bub);
        tick();
        chk("st_e2_exe1", d1_exe, i_s);
        chk("st_e2_stall3", d3_stall, 1'b1);
        tick();
        chk("st_e3_exe3", d3_exe, c_bub);
        tick();
        chk("st_e4_exe3", d3_exe, i_s);

        // Flush on second stall cycle of the WAIT sequence
        drive(i_l3);
        tick();
        drive(i_c3); #1;
        chk("fl_haz_stall3", d3_stall, 1'b1);
        tick();
        flush = 1'b1; #1;
        chk("fl_gate_stall3", d3_stall, 1'b0);
        chk("fl_gate_stall1", d1_stall, 1'b0);
        tick();
        flush = 1'b0;
        drive(i_n); #1;
        chk("fl_exe3", d3_exe, c_bub);
        chk("fl_run_stall3", d3_stall, 1'b0);
        tick();
        chk("fl_next_exe1", d1_exe, i_n);
        chk("fl_next_exe3", d3_exe, i_n);
`ifdef HAZARD_STATS_EN
        chk("stat_b1", d1_sb, 16'd3);
        chk("stat_b3", d3_sb, 16'd7);
        chk("stat_f1", d1_sf, 16'd1);
        chk("stat_f3", d3_sf, 16'd1);
`endif

        // Downstream hold
        ext_hold = 1'b1;
        drive(i_m);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("hold_stall1", d1_stall, 1'b1);
            chk("hold_stall3", d3_stall, 1'b1);
            tick();
            chk("hold_exe1", d1_exe, i_n);
            chk("hold_exe3", d3_exe, i_n);
        end
        ext_hold = 1'b0;
        tick();
        chk("hold_rel_exe3", d3_exe, i_m);

        // Asynchronous reset while in WAIT
        drive(i_l4);
        tick();
        drive(i_c4);
        tick();
        chk("ar_wait_stall3", d3_stall, 1'b1);
        rst_n = 1'b0; #1;
        chk("ar_exe1", d1_exe, c_bub);
        chk("ar_exe3", d3_exe, c_bub);
        chk("ar_stall3", d3_stall, 1'b0);
        #1 rst_n = 1'b1;
        tick();
        chk("ar_run_exe3", d3_exe, i_c4);
`ifdef HAZARD_STATS_EN
        chk("ar_stat_b3", d3_sb, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
